// File: rtl/processor_multi_param_pkg.sv
// Shared definitions for the parametrised multi-cycle accumulator processor:
// FSM state codes, opcode values, instruction field positions and small
// opcode-class helpers used by both the top level and the ALU.
package processor_multi_param_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  // Instruction word layout: op=[15:12], r=[11:8], imm=[7:0]
  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int R_HI   = 11;
  localparam int R_LO   = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_MOV_AR = 4'h1;  // A <- R[r]
  localparam logic [3:0] OP_MOV_RA = 4'h2;  // R[r] <- A
  localparam logic [3:0] OP_MVI    = 4'h3;
  localparam logic [3:0] OP_ADD    = 4'h4;
  localparam logic [3:0] OP_ADC    = 4'h5;
  localparam logic [3:0] OP_SUB    = 4'h6;
  localparam logic [3:0] OP_SBB    = 4'h7;
  localparam logic [3:0] OP_ANA    = 4'h8;
  localparam logic [3:0] OP_ORA    = 4'h9;
  localparam logic [3:0] OP_XRA    = 4'hA;
  localparam logic [3:0] OP_CMP    = 4'hB;
  localparam logic [3:0] OP_JMP    = 4'hC;
  localparam logic [3:0] OP_JZ     = 4'hD;
  localparam logic [3:0] OP_JC     = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  // ALU-class ops (ADD..CMP) are the only ones that touch z/cy.
  function automatic logic sets_flags(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_CMP);
  endfunction

  // CMP computes like SUB but leaves the accumulator alone.
  function automatic logic writes_acc(input logic [3:0] op);
    return (op == OP_MOV_AR) || (op == OP_MVI) ||
           ((op >= OP_ADD) && (op <= OP_XRA));
  endfunction

endpackage

// File: rtl/processor_multi_param_alu.sv
// Combinational ALU for the accumulator processor.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: op (opcode), a (accumulator), b (operand), cin (carry/borrow in);
//        result (DATA_W), cout (bit DATA_W of sum/difference, 0 for logic ops), zero.
module processor_multi_param_alu
  import processor_multi_param_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic              cout,
  output logic              zero
);

  localparam int W1 = DATA_W + 1;

  logic [DATA_W:0] wide;

  // Arithmetic runs one bit wider so bit DATA_W is the carry (add) or the
  // borrow (subtract, as the sign of the two's-complement difference).
  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:          wide = {1'b0, a} + {1'b0, b};
      OP_ADC:          wide = {1'b0, a} + {1'b0, b} + W1'(cin);
      OP_SUB, OP_CMP:  wide = {1'b0, a} - {1'b0, b};
      OP_SBB:          wide = {1'b0, a} - {1'b0, b} - W1'(cin);
      OP_ANA:          wide = {1'b0, a & b};
      OP_ORA:          wide = {1'b0, a | b};
      OP_XRA:          wide = {1'b0, a ^ b};
      default:         wide = {1'b0, a};
    endcase
  end

  assign result = wide[DATA_W-1:0];
  assign cout   = wide[DATA_W];
  assign zero   = (wide[DATA_W-1:0] == '0);

endmodule

// File: rtl/processor_multi_param.sv
// Parametrised multi-cycle accumulator processor (FETCH/DECODE/EXECUTE/WRITEBACK).
// Latency: 4 cycles per instruction plus one per cycle imem_ack is withheld.
// Backpressure: FETCH holds imem_req=1 with a stable imem_addr until imem_ack.
// Ports: clk, reset (async active-low), start (leave IDLE), imem_req/addr/ack/data
//        (fetch handshake), ld_we/addr/data (register preload, IDLE/HALT only),
//        acc, z, cy, pc, state, halted (architectural state for observers).
module processor_multi_param
  import processor_multi_param_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  input  logic              ld_we,
  input  logic [3:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] acc,
  output logic              z,
  output logic              cy,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        state,
  output logic              halted
);

  state_t            cur, nxt;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] ex_res;
  logic              ex_cy, ex_z;

  logic [3:0]        op, ridx;
  logic [DATA_W-1:0] rd_val, imm_ext, exe_res;
  logic              exe_cy, exe_z, jmp_take;
  logic [DATA_W-1:0] alu_res;
  logic              alu_cout, alu_zero;

  assign op   = ir[OP_HI:OP_LO];
  assign ridx = ir[R_HI:R_LO];

  assign state     = cur;
  assign imem_req  = (cur == S_FETCH);
  assign imem_addr = pc;
  assign halted    = (cur == S_HALT);

  // Indices at or above NREG read as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREG; i++)
      if (ridx == 4'(i)) rd_val = regs[i];
  end

  // imm zero-extended to DATA_W, or truncated when DATA_W < 8.
  always_comb begin
    imm_ext = '0;
    for (int i = 0; i < DATA_W; i++)
      imm_ext[i] = (i < 8) ? ir[IMM_LO + (i % 8)] : 1'b0;
  end

  assign jmp_take = (op == OP_JMP) || ((op == OP_JZ) && z) || ((op == OP_JC) && cy);

  processor_multi_param_alu #(.DATA_W(DATA_W)) u_alu (
    .op     (op),
    .a      (acc),
    .b      (opnd),
    .cin    (cy),
    .result (alu_res),
    .cout   (alu_cout),
    .zero   (alu_zero)
  );

  // Result and flags staged in EXECUTE, committed in WRITEBACK.
  always_comb begin
    exe_res = acc;
    exe_cy  = cy;
    exe_z   = z;
    case (op)
      OP_MOV_AR: exe_res = opnd;
      OP_MVI:    exe_res = imm_ext;
      default: begin
        if (sets_flags(op)) begin
          exe_res = alu_res;
          exe_cy  = alu_cout;
          exe_z   = alu_zero;
        end
      end
    endcase
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_IDLE:      if (start) nxt = S_FETCH;
      S_FETCH:     if (imem_ack) nxt = S_DECODE;
      S_DECODE:    nxt = S_EXECUTE;
      S_EXECUTE:   nxt = S_WRITEBACK;
      S_WRITEBACK: nxt = (op == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:      nxt = S_HALT;
      default:     nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      z      <= 1'b0;
      cy     <= 1'b0;
      pc     <= '0;
      ir     <= '0;
      opnd   <= '0;
      ex_res <= '0;
      ex_cy  <= 1'b0;
      ex_z   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (cur)
        S_IDLE, S_HALT: begin
          if (ld_we)
            for (int i = 0; i < NREG; i++)
              if (ld_addr == 4'(i)) regs[i] <= ld_data;
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir <= imem_data;
            pc <= pc + PC_W'(1);
          end
        end
        S_DECODE: opnd <= rd_val;
        S_EXECUTE: begin
          ex_res <= exe_res;
          ex_cy  <= exe_cy;
          ex_z   <= exe_z;
        end
        S_WRITEBACK: begin
          if (writes_acc(op)) acc <= ex_res;
          if (sets_flags(op)) begin
            z  <= ex_z;
            cy <= ex_cy;
          end
          if (op == OP_MOV_RA)
            for (int i = 0; i < NREG; i++)
              if (ridx == 4'(i)) regs[i] <= acc;
          // pc was already incremented in FETCH; a taken jump replaces it.
          if (jmp_take) pc <= ir[PC_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_processor_multi_param.sv
module tb_processor_multi_param;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_b, start, imem_ack, ld_we;
  logic [15:0] imem_data;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;

  logic        req_a, z_a, cy_a, halted_a;
  logic [7:0]  addr_a, acc_a, pc_a;
  logic [2:0]  state_a;
  logic        req_b, z_b, cy_b, halted_b;
  logic [7:0]  addr_b, pc_b;
  logic [15:0] acc_b;
  logic [2:0]  state_b;

  processor_multi_param #(.DATA_W(8), .NREG(8), .PC_W(8)) dut_a (
    .clk(clk), .reset(reset_a), .start(start),
    .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack), .imem_data(imem_data),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data[7:0]),
    .acc(acc_a), .z(z_a), .cy(cy_a), .pc(pc_a), .state(state_a), .halted(halted_a)
  );

  processor_multi_param #(.DATA_W(16), .NREG(4), .PC_W(8)) dut_b (
    .clk(clk), .reset(reset_b), .start(start),
    .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack), .imem_data(imem_data),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data[15:0]),
    .acc(acc_b), .z(z_b), .cy(cy_b), .pc(pc_b), .state(state_b), .halted(halted_b)
  );

  // Observed view of whichever instance is under test.
  logic        sel;
  logic [31:0] o_acc, o_addr, o_pc, o_state;
  logic        o_req, o_z, o_cy, o_halted;
  always_comb begin
    o_acc    = sel ? {16'b0, acc_b} : {24'b0, acc_a};
    o_addr   = sel ? {24'b0, addr_b} : {24'b0, addr_a};
    o_pc     = sel ? {24'b0, pc_b} : {24'b0, pc_a};
    o_state  = sel ? {29'b0, state_b} : {29'b0, state_a};
    o_req    = sel ? req_b : req_a;
    o_z      = sel ? z_b : z_a;
    o_cy     = sel ? cy_b : cy_a;
    o_halted = sel ? halted_b : halted_a;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model (architectural level) ----------------
  int          dw, nreg, pcw;
  longint      m_acc, m_r [16];
  bit          m_z, m_cy, m_halt;
  int          m_pc;
  logic [15:0] prog [256];

  function automatic longint dmask();
    return (longint'(1) << dw) - 1;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_z = 0; m_cy = 0; m_pc = 0; m_halt = 0;
    for (int i = 0; i < 16; i++) m_r[i] = 0;
  endtask

  task automatic model_step(input logic [15:0] w);
    int op, r, imm;
    longint opv, s, c, mask;
    op = w[15:12]; r = w[11:8]; imm = w[7:0];
    mask = dmask();
    m_pc = (m_pc + 1) % (1 << pcw);
    opv = (r < nreg) ? m_r[r] : 0;
    c = 0;
    if ((op == 5 || op == 7) && m_cy) c = 1;
    case (op)
      1: m_acc = opv;
      2: if (r < nreg) m_r[r] = m_acc;
      3: m_acc = imm & mask;
      4, 5: begin
        s = m_acc + opv + c;
        m_cy = (s > mask); m_acc = s & mask; m_z = (m_acc == 0);
      end
      6, 7, 11: begin
        s = m_acc - opv - c;
        m_cy = (s < 0); m_z = ((s & mask) == 0);
        if (op != 11) m_acc = s & mask;
      end
      8, 9, 10: begin
        s = (op == 8) ? (m_acc & opv) : (op == 9) ? (m_acc | opv) : (m_acc ^ opv);
        m_acc = s; m_z = (s == 0); m_cy = 0;
      end
      12: m_pc = imm % (1 << pcw);
      13: if (m_z) m_pc = imm % (1 << pcw);
      14: if (m_cy) m_pc = imm % (1 << pcw);
      15: m_halt = 1;
      default: ;
    endcase
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic reset_dut();
    if (sel) reset_b = 1'b0; else reset_a = 1'b0;
    start = 0; imem_ack = 0; ld_we = 0;
    #1;
    check("rst_state", o_state, 0);
    check("rst_acc", o_acc, 0);
    check("rst_z", o_z, 0);
    check("rst_cy", o_cy, 0);
    check("rst_pc", o_pc, 0);
    check("rst_req", o_req, 0);
    check("rst_halted", o_halted, 0);
    model_reset();
    @(negedge clk);
    if (sel) reset_b = 1'b1; else reset_a = 1'b1;
    @(negedge clk);
  endtask

  task automatic preload(input int a, input longint d);
    ld_we = 1; ld_addr = 4'(a); ld_data = d[31:0];
    @(negedge clk);
    ld_we = 0;
    if (a < nreg) m_r[a] = d & dmask();
  endtask

  task automatic clear_prog();
    for (int a = 0; a < 256; a++) prog[a] = 16'h0000;
  endtask

  task automatic random_prog();
    logic [15:0] w;
    for (int a = 0; a < 256; a++) begin
      w = 16'($urandom);
      if (w[15:12] == 4'hF && $urandom_range(9, 0) != 0) w[15:12] = 4'h0;
      prog[a] = w;
    end
  endtask

  // One instruction: dly cycles without ack, then ack; poke tries a preload mid-FETCH.
  task automatic do_instr(input int dly, input bit poke);
    logic [15:0] w;
    check("st_fetch", o_state, 1);
    for (int k = 0; k < dly; k++) begin
      check("wait_state", o_state, 1);
      check("wait_req", o_req, 1);
      check("wait_addr", o_addr, 32'(m_pc));
      if (poke && k == 0) begin
        ld_we = 1; ld_addr = 4'd0; ld_data = 32'h55;
      end
      imem_data = 16'($urandom);
      @(negedge clk);
      ld_we = 0;
    end
    check("ack_req", o_req, 1);
    check("ack_addr", o_addr, 32'(m_pc));
    w = prog[m_pc];
    imem_ack = 1; imem_data = w;
    @(negedge clk);
    imem_ack = 0; imem_data = 16'($urandom);
    model_step(w);
    repeat (3) @(negedge clk);
    check("end_state", o_state, m_halt ? 5 : 1);
    check("acc", o_acc, 32'(m_acc));
    check("z", o_z, m_z);
    check("cy", o_cy, m_cy);
    check("pc", o_pc, 32'(m_pc));
    check("halted", o_halted, m_halt);
  endtask

  task automatic run_prog(input int max_instr, input int max_dly, input bit chk_cycles);
    int c0, expc, d;
    start = 1;
    @(negedge clk);
    start = 0;
    c0 = cyc; expc = 0;
    for (int i = 0; i < max_instr && !m_halt; i++) begin
      d = (max_dly > 0) ? $urandom_range(max_dly, 0) : 0;
      expc += 4 + d;
      do_instr(d, 1'b0);
    end
    if (chk_cycles) check("halt_cycles", cyc - c0, expc);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset_a = 0; reset_b = 0; start = 0; imem_ack = 0; imem_data = 0;
    ld_we = 0; ld_addr = 0; ld_data = 0;
    sel = 0; dw = 8; nreg = 8; pcw = 8;
    model_reset();
    @(negedge clk);

    // Basic program, ack every cycle, also verifies R6 write via read-back.
    reset_dut();
    repeat (3) @(negedge clk);
    check("idle_hold", o_state, 0);
    for (int i = 0; i < 6; i++) preload(i, i + 1);
    clear_prog();
    prog[0] = 16'h1000; prog[1] = 16'h4100; prog[2] = 16'h4200; prog[3] = 16'h2600;
    prog[4] = 16'h3000; prog[5] = 16'h1600; prog[6] = 16'hF000;
    run_prog(10, 0, 1);
    check("basic_acc", o_acc, 6);
    start = 1; @(negedge clk); start = 0; @(negedge clk);
    check("halt_sticky", o_state, 5);

    // Carry, borrow, compare.
    reset_dut();
    preload(0, 1); preload(1, 2);
    clear_prog();
    prog[0] = 16'h30FF; prog[1] = 16'h4000; prog[2] = 16'h5000; prog[3] = 16'h3001;
    prog[4] = 16'h6100; prog[5] = 16'h3002; prog[6] = 16'hB100; prog[7] = 16'hF000;
    run_prog(10, 0, 0);
    check("cmp_acc", o_acc, 2);
    check("cmp_z", o_z, 1);

    // Jumps: taken JZ, untaken JZ, JMP 0xFF then wrap.
    reset_dut();
    preload(0, 1);
    clear_prog();
    prog[8'h00] = 16'h30FF; prog[8'h01] = 16'h4000; prog[8'h02] = 16'hD010;
    prog[8'h10] = 16'h3001; prog[8'h11] = 16'h9000; prog[8'h12] = 16'hD020;
    prog[8'h13] = 16'hC0FF; prog[8'hFF] = 16'h0000;
    run_prog(8, 0, 0);
    check("pc_wrap", o_pc, 0);

    // Delayed ack with a preload attempt during FETCH (must be ignored).
    reset_dut();
    preload(0, 8'h22);
    clear_prog();
    prog[0] = 16'h1000; prog[1] = 16'hF000;
    start = 1; @(negedge clk); start = 0;
    do_instr(3, 1'b1);
    do_instr(0, 1'b0);
    check("poke_acc", o_acc, 8'h22);

    // Reset asserted mid-instruction in EXECUTE.
    reset_dut();
    preload(0, 1);
    clear_prog();
    prog[0] = 16'h3080; prog[1] = 16'h4000;
    start = 1; @(negedge clk); start = 0;
    do_instr(0, 1'b0);
    imem_ack = 1; imem_data = prog[1];
    @(negedge clk);
    imem_ack = 0;
    @(negedge clk);
    check("in_execute", o_state, 3);
    reset_dut();

    // Randomized programs on the 8-bit instance.
    for (int t = 0; t < 6; t++) begin
      reset_dut();
      for (int i = 0; i < 4; i++) preload($urandom_range(15, 0), longint'($urandom));
      for (int i = 0; i < 8; i++) preload(i, longint'($urandom));
      random_prog();
      run_prog(40, 3, 1'b0);
    end

    // Wide instance: DATA_W=16, NREG=4.
    reset_a = 0;
    sel = 1; dw = 16; nreg = 4; pcw = 8;
    reset_dut();
    preload(3, 64'hFF01);
    preload(5, 64'h1234);
    clear_prog();
    prog[0] = 16'h30FF; prog[1] = 16'h4300; prog[2] = 16'h2500; prog[3] = 16'h1500;
    prog[4] = 16'hF000;
    run_prog(10, 1, 1'b0);
    check("wide_acc", o_acc, 0);
    for (int t = 0; t < 4; t++) begin
      reset_dut();
      for (int i = 0; i < 6; i++) preload($urandom_range(7, 0), longint'($urandom));
      random_prog();
      run_prog(40, 2, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
